// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator subsystem: default sizing, the request
// sequencer state type and the floor number type.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 16;
    localparam int unsigned FLOOR_W    = 4;
    localparam int unsigned GAP_CYCLES = 2;

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

endpackage

// File: rtl/hall_call_dispatcher_if.sv
// Hall-call bundle: button/lift-position inputs towards the dispatcher and the
// request strobe plus lamp/busy status back out.
interface hall_call_dispatcher_if #(
    parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W
);

    logic [NUM_FLOORS-1:0] btn_press;
    logic [FLOOR_W-1:0]    floor_l1;
    logic [FLOOR_W-1:0]    floor_l2;
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_new;
    logic [NUM_FLOORS-1:0] call_lamp;
    logic                  busy;

    modport master (
        input  btn_press, floor_l1, floor_l2,
        output req_valid, req_new, call_lamp, busy
    );

    modport slave (
        output btn_press, floor_l1, floor_l2,
        input  req_valid, req_new, call_lamp, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: grants the first set req bit at index >= ptr,
// wrapping modulo NUM_FLOORS.
module rr_arbiter #(
    parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]    ptr,
    output logic                  gnt_valid,
    output logic [FLOOR_W-1:0]    gnt_idx
);

    logic [NUM_FLOORS-1:0] req_rot;
    int unsigned           idx;

    // Rotating a doubled copy makes the wrap happen at NUM_FLOORS, not 2**FLOOR_W.
    assign req_rot = NUM_FLOORS'({req, req} >> ptr);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (!gnt_valid && req_rot[i]) begin
                gnt_valid = 1'b1;
                idx       = 32'(ptr) + i;
                if (idx >= NUM_FLOORS) begin
                    idx = idx - NUM_FLOORS;
                end
                gnt_idx   = FLOOR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Hall-call front end: holds button presses as pending calls and serialises them
// round-robin onto the single-cycle req_valid/req_new strobe for elevator_system.
module hall_call_dispatcher #(
    parameter int unsigned NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int unsigned FLOOR_W    = elevator_pkg::FLOOR_W,
    parameter int unsigned GAP_CYCLES = elevator_pkg::GAP_CYCLES
) (
    input logic                    clk,
    input logic                    rst_n,
    hall_call_dispatcher_if.master bus
);

    import elevator_pkg::*;

    localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] dispatched_q, dispatched_d;
    logic [FLOOR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [FLOOR_W-1:0]    req_new_q, req_new_d;
    logic [CNT_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [NUM_FLOORS-1:0] arr;
    logic [NUM_FLOORS-1:0] cand;
    logic                  gnt_valid;
    logic [FLOOR_W-1:0]    gnt_idx;
    logic                  take;

    // Lift positions outside 0..NUM_FLOORS-1 never match any floor index.
    always_comb begin
        arr = '0;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            arr[f] = (32'(bus.floor_l1) == f) || (32'(bus.floor_l2) == f);
        end
    end

    assign cand = pending_q & ~arr;

    rr_arbiter #(
        .NUM_FLOORS(NUM_FLOORS),
        .FLOOR_W   (FLOOR_W)
    ) u_arb (
        .req      (cand),
        .ptr      (rr_ptr_q),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    assign take = (state_q == IDLE) && gnt_valid;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        req_new_d = req_new_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d   = ISSUE;
                    req_new_d = gnt_idx;
                    rr_ptr_d  = (32'(gnt_idx) == NUM_FLOORS - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
            ISSUE: begin
                state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
                gap_cnt_d = '0;
            end
            GAP: begin
                if (gap_cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arrival beats a new press, which beats moving the granted call to dispatched.
    always_comb begin
        pending_d    = pending_q;
        dispatched_d = dispatched_q;
        for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
            if (arr[f]) begin
                pending_d[f]    = 1'b0;
                dispatched_d[f] = 1'b0;
            end else if (bus.btn_press[f] && !pending_q[f] && !dispatched_q[f]) begin
                pending_d[f] = 1'b1;
            end else if (take && (32'(gnt_idx) == f)) begin
                pending_d[f]    = 1'b0;
                dispatched_d[f] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pending_q    <= '0;
            dispatched_q <= '0;
            rr_ptr_q     <= '0;
            req_new_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            dispatched_q <= dispatched_d;
            rr_ptr_q     <= rr_ptr_d;
            req_new_q    <= req_new_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign bus.req_valid = (state_q == ISSUE);
    assign bus.req_new   = req_new_q;
    assign bus.call_lamp = pending_q | dispatched_q;
    assign bus.busy      = |(pending_q | dispatched_q);

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Bench for hall_call_dispatcher: a 16-floor and a 10-floor instance driven with
// directed scenarios and random traffic, checked against a call-list model.
module tb_hall_call_dispatcher;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hall_call_dispatcher_if #(.NUM_FLOORS(16), .FLOOR_W(4)) bus0 ();
    hall_call_dispatcher_if #(.NUM_FLOORS(10), .FLOOR_W(4)) bus1 ();

    hall_call_dispatcher #(.NUM_FLOORS(16), .FLOOR_W(4), .GAP_CYCLES(2)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    hall_call_dispatcher #(.NUM_FLOORS(10), .FLOOR_W(4), .GAP_CYCLES(1)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] cur_btn;
    int          cur_f1, cur_f2;

    // Reference: per instance, a set of waiting calls, a set of sent calls, the
    // next search start, and how many cycles remain before another send is allowed.
    bit mp[2][16];
    bit md[2][16];
    int mrr[2];
    int mhold[2];
    int mrn[2];
    bit mv[2];

    int log0[$], log1[$], st0[$], st1[$];

    function automatic int nf_of(input int k);
        return (k == 0) ? 16 : 10;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int f = 0; f < 16; f++) begin
                mp[k][f] = 1'b0;
                md[k][f] = 1'b0;
            end
            mrr[k]   = 0;
            mhold[k] = 0;
            mrn[k]   = 0;
            mv[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int nf;
        int sel;
        bit here[16];
        nf  = nf_of(k);
        sel = -1;
        for (int f = 0; f < 16; f++) here[f] = (f < nf) && (cur_f1 == f || cur_f2 == f);
        if (mhold[k] == 0) begin
            for (int i = 0; i < nf; i++) begin
                int c;
                c = (mrr[k] + i) % nf;
                if (sel < 0 && mp[k][c] && !here[c]) sel = c;
            end
        end
        for (int f = 0; f < nf; f++) begin
            if (here[f]) begin
                mp[k][f] = 1'b0;
                md[k][f] = 1'b0;
            end else if (cur_btn[f] && !mp[k][f] && !md[k][f]) begin
                mp[k][f] = 1'b1;
            end else if (f == sel) begin
                mp[k][f] = 1'b0;
                md[k][f] = 1'b1;
            end
        end
        if (sel >= 0) begin
            mv[k]    = 1'b1;
            mrn[k]   = sel;
            mrr[k]   = (sel + 1) % nf;
            mhold[k] = 1 + gap_of(k);
        end else begin
            mv[k] = 1'b0;
            if (mhold[k] > 0) mhold[k]--;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] lv;
        for (int k = 0; k < 2; k++) begin
            lv = '0;
            for (int f = 0; f < nf_of(k); f++) begin
                if (mp[k][f] || md[k][f]) lv = lv | (32'd1 << f);
            end
            check($sformatf("%s.d%0d.req_valid", tag, k),
                  (k == 0) ? 32'(bus0.req_valid) : 32'(bus1.req_valid), 32'(mv[k]));
            check($sformatf("%s.d%0d.req_new", tag, k),
                  (k == 0) ? 32'(bus0.req_new) : 32'(bus1.req_new), 32'(mrn[k]));
            check($sformatf("%s.d%0d.call_lamp", tag, k),
                  (k == 0) ? 32'(bus0.call_lamp) : 32'(bus1.call_lamp), lv);
            check($sformatf("%s.d%0d.busy", tag, k),
                  (k == 0) ? 32'(bus0.busy) : 32'(bus1.busy), 32'(lv != 0));
        end
    endtask

    task automatic set_in(input logic [15:0] btn, input int f1, input int f2);
        cur_btn = btn;
        cur_f1  = f1;
        cur_f2  = f2;
        bus0.btn_press = btn;
        bus0.floor_l1  = 4'(f1);
        bus0.floor_l2  = 4'(f2);
        bus1.btn_press = btn[9:0];
        bus1.floor_l1  = 4'(f1);
        bus1.floor_l2  = 4'(f2);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) begin
                model_step(0);
                model_step(1);
            end
            #1;
            cyc++;
            check_all($sformatf("cyc%0d", cyc));
            if (bus0.req_valid === 1'b1) begin
                log0.push_back(int'(bus0.req_new));
                st0.push_back(cyc);
            end
            if (bus1.req_valid === 1'b1) begin
                log1.push_back(int'(bus1.req_new));
                st1.push_back(cyc);
            end
        end
    endtask

    task automatic clear_logs();
        log0.delete();
        log1.delete();
        st0.delete();
        st1.delete();
    endtask

    task automatic reset_check(input string tag);
        check({tag, ".d0.req_valid"}, 32'(bus0.req_valid), 32'd0);
        check({tag, ".d0.call_lamp"}, 32'(bus0.call_lamp), 32'd0);
        check({tag, ".d0.busy"},      32'(bus0.busy),      32'd0);
        check({tag, ".d1.req_valid"}, 32'(bus1.req_valid), 32'd0);
        check({tag, ".d1.call_lamp"}, 32'(bus1.call_lamp), 32'd0);
        check({tag, ".d1.busy"},      32'(bus1.busy),      32'd0);
    endtask

    initial begin
        logic [15:0] rbtn;
        int          rf1, rf2;

        rst_n = 1'b1;
        set_in(16'h0000, 0, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        reset_check("reset");
        check("reset.d0.req_new", 32'(bus0.req_new), 32'd0);
        #10 rst_n = 1'b1;
        tick(2);

        // Single call at floor 4: strobe on the second edge, lamp until a lift arrives.
        clear_logs();
        set_in(16'h0010, 0, 0);
        tick(1);
        check("t1.no_early_valid", 32'(bus0.req_valid), 32'd0);
        set_in(16'h0000, 0, 0);
        tick(1);
        check("t1.valid", 32'(bus0.req_valid), 32'd1);
        check("t1.floor", 32'(bus0.req_new), 32'd4);
        check("t1.floor10", 32'(bus1.req_new), 32'd4);
        tick(1);
        check("t1.one_cycle", 32'(bus0.req_valid), 32'd0);
        check("t1.lamp4", 32'(bus0.call_lamp[4]), 32'd1);
        tick(3);
        set_in(16'h0000, 4, 0);
        tick(1);
        check("t1.lamp_clear", 32'(bus0.call_lamp), 32'd0);
        check("t1.busy_clear", 32'(bus0.busy), 32'd0);
        set_in(16'h0000, 0, 0);
        tick(1);

        // Floors 2 and 8 together with the pointer at 5: 8 first, then 2.
        clear_logs();
        set_in(16'h0104, 0, 0);
        tick(1);
        set_in(16'h0000, 0, 0);
        tick(8);
        check("t2.count", 32'(log0.size()), 32'd2);
        check("t2.first", 32'(log0[0]), 32'd8);
        check("t2.second", 32'(log0[1]), 32'd2);
        check("t2.spacing", 32'(st0[1] - st0[0]), 32'd4);
        check("t2.first10", 32'(log1[0]), 32'd8);
        check("t2.second10", 32'(log1[1]), 32'd2);
        check("t2.spacing10", 32'(st1[1] - st1[0]), 32'd3);

        // Holding the button of a dispatched floor issues nothing more.
        clear_logs();
        set_in(16'h0100, 0, 0);
        tick(10);
        check("t3.no_repeat", 32'(log0.size()), 32'd0);
        check("t3.lamp8", 32'(bus0.call_lamp[8]), 32'd1);
        set_in(16'h0000, 0, 8);
        tick(1);
        check("t3.lamp8_clear", 32'(bus0.call_lamp[8]), 32'd0);
        set_in(16'h0000, 2, 8);
        tick(1);
        check("t3.busy_clear", 32'(bus0.busy), 32'd0);

        // Press where a lift already stands is absorbed.
        clear_logs();
        set_in(16'h0000, 0, 6);
        tick(1);
        set_in(16'h0040, 0, 6);
        tick(3);
        set_in(16'h0000, 0, 6);
        tick(3);
        check("t4.no_request", 32'(log0.size()), 32'd0);
        check("t4.lamp6", 32'(bus0.call_lamp[6]), 32'd0);
        check("t4.lamp6_10", 32'(bus1.call_lamp[6]), 32'd0);

        // Wrap-around: pointer at 15 (16 floors) and at 9 (10 floors).
        clear_logs();
        set_in(16'h0100, 3, 7);
        tick(1);
        set_in(16'h0000, 3, 7);
        tick(6);
        check("t5a.d0", 32'(log0[0]), 32'd8);
        check("t5a.d1", 32'(log1[0]), 32'd8);
        clear_logs();
        set_in(16'h4000, 3, 7);
        tick(1);
        set_in(16'h0000, 3, 7);
        tick(6);
        check("t5b.d0", 32'(log0[0]), 32'd14);
        check("t5b.d1_none", 32'(log1.size()), 32'd0);
        clear_logs();
        set_in(16'h8201, 3, 7);
        tick(1);
        set_in(16'h0000, 3, 7);
        tick(14);
        check("t5c.d0.count", 32'(log0.size()), 32'd3);
        check("t5c.d0.first", 32'(log0[0]), 32'd15);
        check("t5c.d0.second", 32'(log0[1]), 32'd0);
        check("t5c.d0.third", 32'(log0[2]), 32'd9);
        check("t5c.d1.count", 32'(log1.size()), 32'd2);
        check("t5c.d1.first", 32'(log1[0]), 32'd9);
        check("t5c.d1.second", 32'(log1[1]), 32'd0);

        // Reset during the gap with three calls outstanding.
        set_in(16'h0026, 12, 13);
        tick(1);
        set_in(16'h0000, 12, 13);
        tick(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        reset_check("t6.async");
        tick(1);
        #3 rst_n = 1'b1;
        clear_logs();
        tick(10);
        check("t6.no_replay0", 32'(log0.size()), 32'd0);
        check("t6.no_replay1", 32'(log1.size()), 32'd0);
        check("t6.idle_busy", 32'(bus0.busy), 32'd0);

        // Random traffic with moving lifts.
        rf1 = 0;
        rf2 = 0;
        for (int i = 0; i < 400; i++) begin
            rbtn = '0;
            if ($urandom_range(0, 2) == 0) rbtn = 16'd1 << $urandom_range(0, 15);
            if ($urandom_range(0, 11) == 0) rbtn = 16'($urandom);
            if ($urandom_range(0, 4) == 0) rf1 = int'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) rf2 = int'($urandom_range(0, 15));
            set_in(rbtn, rf1, rf2);
            tick(1);
        end
        set_in(16'h0000, rf1, rf2);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
